// File: rtl/int_rf_wb_arbiter_pkg.sv
// int_rf_wb_arbiter_pkg: datapath widths and the write-back request type shared by the arbiter.
package int_rf_wb_arbiter_pkg;
  localparam int XLEN = 32;
  localparam int REG_IDX_LEN = 5;
  localparam int RF_WB_REQ_NUM = 2;
  typedef struct packed {
    logic [REG_IDX_LEN-1:0] rd_idx;
    logic [XLEN-1:0]        rd_value;
  } rf_wb_req_t;
endpackage

// File: rtl/int_rf_wb_arbiter_rr_arbiter.sv
// int_rf_wb_arbiter_rr_arbiter: combinational round-robin pick of the first set request at or after ptr.
module int_rf_wb_arbiter_rr_arbiter #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);
  int j;
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    j = 0;
    // Scan from the farthest offset down so the nearest-to-ptr request wins last.
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      j = (j >= N) ? j - N : j;
      if (en && req[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/int_rf_wb_arbiter.sv
// int_rf_wb_arbiter: round-robin sharing of the register-file write port with a one-entry output stage.
module int_rf_wb_arbiter
  import int_rf_wb_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  localparam int PW = $clog2(N_REQ)
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic [N_REQ-1:0]                   req_valid_i,
  output logic [N_REQ-1:0]                   req_ready_o,
  input  logic [N_REQ-1:0][REG_IDX_LEN-1:0]  req_rd_idx_i,
  input  logic [N_REQ-1:0][XLEN-1:0]         req_rd_value_i,
  output logic                               rf_valid_o,
  input  logic                               rf_ready_i,
  output logic [REG_IDX_LEN-1:0]             rf_rd_idx_o,
  output logic [XLEN-1:0]                    rf_rd_value_o,
  output logic [PW-1:0]                      rr_ptr_o
);
  logic valid_q, valid_d;
  rf_wb_req_t wb_q, wb_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic can_load, hs, nz;
  logic [N_REQ-1:0] gnt;
  logic [PW-1:0] gnt_idx;
  assign can_load = !valid_q || rf_ready_i;
  int_rf_wb_arbiter_rr_arbiter #(.N(N_REQ)) u_arb (
    .req(req_valid_i),
    .ptr(rr_ptr_q),
    .en(can_load),
    .gnt(gnt),
    .gnt_idx(gnt_idx)
  );
  // Writes to x0 are accepted but never reach the register file.
  always_comb begin
    hs = |gnt;
    nz = req_rd_idx_i[gnt_idx] != '0;
    valid_d = can_load ? hs && nz : valid_q;
    wb_d = (hs && nz) ? '{rd_idx: req_rd_idx_i[gnt_idx], rd_value: req_rd_value_i[gnt_idx]} : wb_q;
    rr_ptr_d = hs ? ((gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1) : rr_ptr_q;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      wb_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      valid_q <= valid_d;
      wb_q <= wb_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
  assign req_ready_o = gnt;
  assign rf_valid_o = valid_q;
  assign rf_rd_idx_o = wb_q.rd_idx;
  assign rf_rd_value_o = wb_q.rd_value;
  assign rr_ptr_o = rr_ptr_q;
endmodule

// File: tb/tb_int_rf_wb_arbiter.sv
// tb_int_rf_wb_arbiter: directed and random checks of the write-back arbiter against a queue-based model.
module tb_int_rf_wb_arbiter;
  import int_rf_wb_arbiter_pkg::*;
  localparam int N = 4;
  localparam int PW = 2;
  logic clk = 1'b0;
  logic rst_n_i = 1'b1;
  logic [N-1:0] req_valid_i, req_ready_o;
  logic [N-1:0][REG_IDX_LEN-1:0] req_rd_idx_i;
  logic [N-1:0][XLEN-1:0] req_rd_value_i;
  logic rf_valid_o, rf_ready_i;
  logic [REG_IDX_LEN-1:0] rf_rd_idx_o;
  logic [XLEN-1:0] rf_rd_value_o;
  logic [PW-1:0] rr_ptr_o;
  always #5 clk = ~clk;

  int_rf_wb_arbiter #(.N_REQ(N)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_rd_idx_i(req_rd_idx_i), .req_rd_value_i(req_rd_value_i),
    .rf_valid_o(rf_valid_o), .rf_ready_i(rf_ready_i),
    .rf_rd_idx_o(rf_rd_idx_o), .rf_rd_value_o(rf_rd_value_o),
    .rr_ptr_o(rr_ptr_o)
  );

  typedef struct {logic [REG_IDX_LEN-1:0] i; logic [XLEN-1:0] v;} wr_t;
  int checks = 0, failures = 0;
  bit m_valid;
  logic [REG_IDX_LEN-1:0] m_idx;
  logic [XLEN-1:0] m_val;
  int m_ptr, win;
  int grants[$];
  wr_t exp_wr[$];
  wr_t w;
  logic [REG_IDX_LEN-1:0] snap_idx;
  logic [XLEN-1:0] snap_val;
  logic [3:0] seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    if (m_valid && !rf_ready_i) return -1;
    for (int k = 0; k < N; k++)
      if (req_valid_i[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic do_reset();
    req_valid_i = '0;
    rst_n_i = 1'b0;
    #1;
    chk("rst_valid", rf_valid_o, 0);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_ptr", rr_ptr_o, 0);
    chk("rst_idx", rf_rd_idx_o, 0);
    chk("rst_value", rf_rd_value_o, 0);
    m_valid = 0; m_idx = '0; m_val = '0; m_ptr = 0;
    exp_wr.delete();
    grants.delete();
    @(negedge clk);
    rst_n_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    win = pick();
    chk("ready", req_ready_o, (win < 0) ? 64'd0 : (64'd1 << win));
    chk("rf_valid", rf_valid_o, m_valid);
    if (m_valid) begin
      chk("rf_idx", rf_rd_idx_o, m_idx);
      chk("rf_value", rf_rd_value_o, m_val);
    end
    chk("rr_ptr", rr_ptr_o, m_ptr);
    if (m_valid && rf_ready_i) begin
      chk("sb_nonempty", exp_wr.size() != 0, 1);
      if (exp_wr.size() != 0) begin
        w = exp_wr.pop_front();
        chk("sb_idx", rf_rd_idx_o, w.i);
        chk("sb_value", rf_rd_value_o, w.v);
      end
    end
    if (!m_valid || rf_ready_i) m_valid = 0;
    if (win >= 0) begin
      grants.push_back(win);
      m_ptr = (win + 1) % N;
      if (req_rd_idx_i[win] != 0) begin
        m_valid = 1;
        m_idx = req_rd_idx_i[win];
        m_val = req_rd_value_i[win];
        exp_wr.push_back('{req_rd_idx_i[win], req_rd_value_i[win]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rf_ready_i = 1'b0;
    req_valid_i = '0;
    req_rd_idx_i = '0;
    req_rd_value_i = '0;
    #2;
    do_reset();

    // single requester
    req_valid_i = 4'b0001; req_rd_idx_i[0] = 5'd5; req_rd_value_i[0] = 32'hDEAD_BEEF; rf_ready_i = 1'b1;
    cycle();
    chk("single_win", win, 0);
    req_valid_i = '0;
    chk("single_valid", rf_valid_o, 1);
    chk("single_idx", rf_rd_idx_o, 5);
    chk("single_value", rf_rd_value_o, 32'hDEAD_BEEF);
    chk("single_ptr", rr_ptr_o, 1);
    cycle();

    // contention between req0 and req1
    do_reset();
    req_valid_i = 4'b0011;
    for (int i = 0; i < 2; i++) begin
      req_rd_idx_i[i] = 5'($urandom_range(1, 31));
      req_rd_value_i[i] = $urandom;
    end
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("cont_win", win, k % 2);
      chk("cont_valid", rf_valid_o, 1);
      if (win >= 0) begin
        req_rd_idx_i[win] = 5'($urandom_range(1, 31));
        req_rd_value_i[win] = $urandom;
      end
    end

    // backpressure with req1 waiting
    req_valid_i = 4'b0010; rf_ready_i = 1'b0;
    snap_idx = rf_rd_idx_o; snap_val = rf_rd_value_o;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_ready", req_ready_o, 0);
      chk("bp_hold_idx", rf_rd_idx_o, snap_idx);
      chk("bp_hold_value", rf_rd_value_o, snap_val);
      chk("bp_hold_valid", rf_valid_o, 1);
    end
    rf_ready_i = 1'b1;
    cycle();
    chk("bp_win", win, 1);
    chk("bp_reload_idx", rf_rd_idx_o, req_rd_idx_i[1]);
    chk("bp_reload_value", rf_rd_value_o, req_rd_value_i[1]);

    // reset while the stage is full
    chk("pre_rst_valid", rf_valid_o, 1);
    do_reset();

    // write to x0 is swallowed
    req_valid_i = 4'b0001; req_rd_idx_i[0] = '0; req_rd_value_i[0] = 32'h1234; rf_ready_i = 1'b1;
    cycle();
    chk("x0_win", win, 0);
    req_valid_i = '0;
    chk("x0_valid", rf_valid_o, 0);
    chk("x0_ptr", rr_ptr_o, 1);
    cycle();

    // fairness with all four requesters always valid
    do_reset();
    req_valid_i = 4'b1111;
    for (int i = 0; i < N; i++) begin
      req_rd_idx_i[i] = 5'($urandom_range(1, 31));
      req_rd_value_i[i] = $urandom;
    end
    for (int k = 0; k < 40; k++) begin
      rf_ready_i = 1'($urandom_range(0, 1));
      cycle();
      if (win >= 0) begin
        req_rd_idx_i[win] = 5'($urandom_range(1, 31));
        req_rd_value_i[win] = $urandom;
      end
    end
    for (int i = 0; i + 4 <= grants.size(); i++) begin
      seen = '0;
      for (int j = 0; j < 4; j++) seen[grants[i+j]] = 1'b1;
      chk("fair_window", seen, 4'hF);
    end

    // random traffic, requesters hold until accepted
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid_i[i] || win == i) begin
          req_valid_i[i] = 1'($urandom_range(0, 1));
          req_rd_idx_i[i] = ($urandom_range(0, 3) == 0) ? '0 : 5'($urandom_range(1, 31));
          req_rd_value_i[i] = $urandom;
        end
      rf_ready_i = $urandom_range(0, 3) != 0;
      cycle();
    end
    req_valid_i = '0; rf_ready_i = 1'b1;
    cycle();
    cycle();
    chk("sb_drained", exp_wr.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
